clk_gen_multi: RTL
==================

CLK_GEN_MULTI -- requirements
Module: clk_gen_multi

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent clock-output channels (1..16).
REQ-002 Parameter COUNTER_BITS, default 32, width of the per-channel divider, high-time and phase counter.
REQ-003 Parameter PULSE_BITS, default 32, width of the per-channel pulse/period counter.
REQ-004 Parameter DATA_BITS, default 32, width of cfg_wdata; fields are truncated or zero-extended to the target width.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 cfg_we  in  1  configuration write strobe, one write per cycle.
REQ-008 cfg_ch  in  max(1,$clog2(NUM_CH))  target channel; writes to cfg_ch >= NUM_CH are ignored.
REQ-009 cfg_sel  in  2  target field: 0 divider, 1 high_time, 2 pulse_count, 3 mode (cfg_wdata[1:0]).
REQ-010 cfg_wdata  in  DATA_BITS  write data.
REQ-011 sync_restart  in  1  phase-align all auto-running channels.
REQ-012 clk_o  out  NUM_CH  per-channel generated clock.
REQ-013 busy  out  NUM_CH  channel has pulses/periods outstanding.
REQ-014 done  out  NUM_CH  one-cycle registered strobe when a counted burst finishes.

Function
REQ-015 Each channel SHALL hold registers divider, high_time, pulse_count, mode, cnt and clk_auto; a config write SHALL update only the addressed field on the next edge.
REQ-016 Modes SHALL be: 00 OFF, 01 PULSE, 10 AUTO, 11 COUNTED (auto clock for pulse_count periods).
REQ-017 Effective divider d_eff SHALL be 2 when divider < 2, else divider.
REQ-018 Effective high time h_eff SHALL be d_eff>>1 when high_time = 0, d_eff-1 when high_time >= d_eff, else high_time.
REQ-019 AUTO/COUNTED-running, each edge: clk_auto <= (cnt < h_eff); cnt <= (cnt >= d_eff-1) ? 0 : cnt+1; output period d_eff cycles, high h_eff cycles.
REQ-020 A divider write while running SHALL not reset cnt; if cnt >= new d_eff-1 the counter wraps to 0 on the next edge.
REQ-021 A mode write into AUTO or COUNTED SHALL force cnt = 0 and clk_auto = 0 on that edge.
REQ-022 In AUTO/COUNTED, clk_o SHALL equal clk_auto (registered, glitch-free).
REQ-023 In PULSE, clk_o SHALL equal clk AND (pulse_count != 0) combinationally; pulse_count decrements by 1 each edge while nonzero.
REQ-024 In COUNTED, pulse_count SHALL decrement on each cnt wrap (d_eff-1 -> 0); while pulse_count = 0, cnt holds 0 and clk_auto is forced 0.
REQ-025 A pulse_count write in COUNTED SHALL also force cnt = 0, restarting the burst at a period boundary.
REQ-026 In OFF, clk_o SHALL be 0 and cnt, clk_auto, pulse_count SHALL hold.
REQ-027 busy[i] SHALL be (pulse_count != 0) in PULSE or COUNTED, else 0.
REQ-028 done[i] SHALL assert for exactly one cycle after the edge on which pulse_count decrements 1 -> 0; writing 0 SHALL not assert done.
REQ-029 A pulse_count write coincident with a decrement SHALL win (written value loaded, no decrement, no done).
REQ-030 sync_restart SHALL set cnt = 0 and clk_auto = 0 in every AUTO/COUNTED channel on that edge; a coincident config write to the same channel SHALL also apply.
REQ-031 Counters SHALL not wrap below 0 or overflow; all arithmetic SHALL be unsigned at declared widths.

Reset
REQ-032 While reset = 0 at an edge: divider = 2, high_time = 0, pulse_count = 0, mode = OFF, cnt = 0, clk_auto = 0, done = 0; hence clk_o = 0, busy = 0.
REQ-033 Reset SHALL override config writes and sync_restart, and SHALL abort any burst mid-operation without asserting done.

Verification
REQ-034 ch0 divider=4, mode=AUTO written at edge E0 -> clk_o[0] high after E1,E2, low after E3,E4, repeating period 4.
REQ-035 ch0 divider=5, high_time=1 -> 1 high/4 low; then high_time=7 -> clamped 4 high/1 low; divider=0 -> period 2, 1 high.
REQ-036 ch1 mode=PULSE, pulse_count=3 -> exactly 3 clk pulses on clk_o[1], busy[1] high 3 cycles, done[1] one cycle immediately after.
REQ-037 ch0 mode=COUNTED, divider=4, pulse_count=2 -> exactly 2 periods then clk_o[0]=0, done[0] pulses once, busy[0] falls with it.
REQ-038 ch0 divider=4, ch1 divider=6 both AUTO, free-running, sync_restart pulsed -> both clk_o rise together after the following edge.
REQ-039 reset asserted mid-COUNTED burst -> all outputs 0 after that edge, no done, fields at reset values.

Source files
------------

// File: rtl/clk_gen_multi_if.sv
// clk_gen_multi_if: configuration write bus for clk_gen_multi.
// One field write per cycle, addressed by channel and field select.
interface clk_gen_multi_if #(
    parameter int NUM_CH    = 2,
    parameter int DATA_BITS = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                 cfg_we;
    logic [CH_W-1:0]      cfg_ch;
    logic [1:0]           cfg_sel;
    logic [DATA_BITS-1:0] cfg_wdata;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_sel,
        output cfg_wdata
    );

    modport slave (
        input cfg_we,
        input cfg_ch,
        input cfg_sel,
        input cfg_wdata
    );
endinterface

// File: rtl/clk_gen_multi.sv
// clk_gen_multi: per-channel programmable divider clock, gated
// pulse train and counted burst generator with phase restart.
module clk_gen_multi #(
    parameter int NUM_CH       = 2,
    parameter int COUNTER_BITS = 32,
    parameter int PULSE_BITS   = 32,
    parameter int DATA_BITS    = 32
) (
    input  logic              clk,
    input  logic              reset,
    clk_gen_multi_if.slave    cfg,
    input  logic              sync_restart,
    output logic [NUM_CH-1:0] clk_o,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);
    localparam int CW   = COUNTER_BITS;
    localparam int PW   = PULSE_BITS;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        M_OFF   = 2'd0,
        M_PULSE = 2'd1,
        M_AUTO  = 2'd2,
        M_CNT   = 2'd3
    } mode_e;

    logic [CW-1:0] wd_c;
    logic [PW-1:0] wd_p;

    if (DATA_BITS >= CW) begin : g_wc_trunc
        assign wd_c = cfg.cfg_wdata[CW-1:0];
    end else begin : g_wc_ext
        assign wd_c = {{(CW-DATA_BITS){1'b0}}, cfg.cfg_wdata};
    end

    if (DATA_BITS >= PW) begin : g_wp_trunc
        assign wd_p = cfg.cfg_wdata[PW-1:0];
    end else begin : g_wp_ext
        assign wd_p = {{(PW-DATA_BITS){1'b0}}, cfg.cfg_wdata};
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CW-1:0] div_q, div_d;
        logic [CW-1:0] hi_q, hi_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [PW-1:0] pc_q, pc_d;
        mode_e         mode_q, mode_d;
        logic          auto_q, auto_d;
        logic          done_q, done_d;
        logic [CW-1:0] d_eff, h_eff;
        logic          wr, wrap, pc_nz;

        always_comb begin
            d_eff  = (div_q < CW'(2)) ? CW'(2) : div_q;
            if (hi_q == '0)
                h_eff = d_eff >> 1;
            else if (hi_q >= d_eff)
                h_eff = d_eff - CW'(1);
            else
                h_eff = hi_q;
            wrap   = cnt_q >= (d_eff - CW'(1));
            pc_nz  = pc_q != '0;
            wr     = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));
            div_d  = div_q;
            hi_d   = hi_q;
            cnt_d  = cnt_q;
            pc_d   = pc_q;
            mode_d = mode_q;
            auto_d = auto_q;
            done_d = 1'b0;

            unique case (mode_q)
                M_AUTO: begin
                    auto_d = cnt_q < h_eff;
                    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
                end
                M_CNT: begin
                    if (pc_nz) begin
                        auto_d = cnt_q < h_eff;
                        cnt_d  = wrap ? '0 : cnt_q + CW'(1);
                        if (wrap) begin
                            pc_d   = pc_q - PW'(1);
                            done_d = pc_q == PW'(1);
                        end
                    end else begin
                        cnt_d  = '0;
                        auto_d = 1'b0;
                    end
                end
                M_PULSE: begin
                    if (pc_nz) begin
                        pc_d   = pc_q - PW'(1);
                        done_d = pc_q == PW'(1);
                    end
                end
                default: ;
            endcase

            if (sync_restart && mode_q[1]) begin
                cnt_d  = '0;
                auto_d = 1'b0;
            end

            // Field writes land last so they override the running update.
            if (wr) begin
                unique case (1'b1)
                    cfg.cfg_sel == 2'd0: div_d = wd_c;
                    cfg.cfg_sel == 2'd1: hi_d  = wd_c;
                    cfg.cfg_sel == 2'd2: begin
                        pc_d   = wd_p;
                        done_d = 1'b0;
                        if (mode_q == M_CNT)
                            cnt_d = '0;
                    end
                    cfg.cfg_sel == 2'd3: begin
                        mode_d = mode_e'(cfg.cfg_wdata[1:0]);
                        if (cfg.cfg_wdata[1]) begin
                            cnt_d  = '0;
                            auto_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                div_q  <= CW'(2);
                hi_q   <= '0;
                cnt_q  <= '0;
                pc_q   <= '0;
                mode_q <= M_OFF;
                auto_q <= 1'b0;
                done_q <= 1'b0;
            end else begin
                div_q  <= div_d;
                hi_q   <= hi_d;
                cnt_q  <= cnt_d;
                pc_q   <= pc_d;
                mode_q <= mode_d;
                auto_q <= auto_d;
                done_q <= done_d;
            end
        end

        // PULSE mode gates the system clock directly.
        assign clk_o[i] = mode_q[1] ? auto_q :
                          (mode_q == M_PULSE) ? (clk & pc_nz) :
                          1'b0;
        assign busy[i]  = mode_q[0] & pc_nz;
        assign done[i]  = done_q;
    end
endmodule
